// File: rtl/ll_pkg.sv
// rtl/ll_pkg.sv - shared types and default sizes for the linked-list pointer manager
package ll_pkg;

    localparam int DEF_DATA_DEPTH = 16;
    localparam int DEF_DATA_WD    = 32;
    localparam int DEF_NUM_LISTS  = 4;

    typedef enum logic [2:0] {
        OP_PUSH_TAIL = 3'd0,
        OP_INSERT_AT = 3'd1,
        OP_DELETE_AT = 3'd2,
        OP_READ_AT   = 3'd3,
        OP_CLEAR     = 3'd4
    } ll_op_e;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_FULL  = 2'd1,
        ST_EMPTY = 2'd2,
        ST_BAD   = 2'd3
    } ll_status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } ll_state_e;

endpackage

// File: rtl/ll_free_list.sv
// rtl/ll_free_list.sv - free-node list head/tail/count; link writes live in the owner's nxt_mem
module ll_free_list #(
    parameter int DATA_DEPTH = 16,
    parameter int PTR_WD     = $clog2(DATA_DEPTH),
    parameter int CNT_WD     = PTR_WD + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pop,
    input  logic [PTR_WD-1:0] head_nxt,
    input  logic              push,
    input  logic [PTR_WD-1:0] push_node,
    input  logic              splice,
    input  logic [PTR_WD-1:0] splice_head,
    input  logic [PTR_WD-1:0] splice_tail,
    input  logic [CNT_WD-1:0] splice_cnt,
    output logic [PTR_WD-1:0] free_head,
    output logic [PTR_WD-1:0] free_tail,
    output logic [CNT_WD-1:0] free_cnt
);

    // At most one of pop/push/splice per cycle; an empty free list takes the new node as its head too
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            free_head <= '0;
            free_tail <= PTR_WD'(DATA_DEPTH - 1);
            free_cnt  <= CNT_WD'(DATA_DEPTH);
        end else if (pop) begin
            free_head <= head_nxt;
            free_cnt  <= free_cnt - CNT_WD'(1);
        end else if (push) begin
            if (free_cnt == '0) free_head <= push_node;
            free_tail <= push_node;
            free_cnt  <= free_cnt + CNT_WD'(1);
        end else if (splice) begin
            if (free_cnt == '0) free_head <= splice_head;
            free_tail <= splice_tail;
            free_cnt  <= free_cnt + splice_cnt;
        end
    end

endmodule

// File: rtl/ll_ptr_mgr.sv
// rtl/ll_ptr_mgr.sv - multi-list linked-list manager over a shared node pool
module ll_ptr_mgr
    import ll_pkg::*;
#(
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int DATA_WD    = DEF_DATA_WD,
    parameter int NUM_LISTS  = DEF_NUM_LISTS,
    localparam int PTR_WD    = $clog2(DATA_DEPTH),
    localparam int CNT_WD    = PTR_WD + 1,
    localparam int LID_WD    = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_vld,
    output logic                        req_rdy,
    input  logic [2:0]                  req_op,
    input  logic [LID_WD-1:0]           req_list,
    input  logic [CNT_WD-1:0]           req_pos,
    input  logic [DATA_WD-1:0]          req_data,
    output logic                        resp_vld,
    input  logic                        resp_rdy,
    output logic [DATA_WD-1:0]          resp_data,
    output logic [1:0]                  resp_status,
    output logic [NUM_LISTS-1:0]        ll_empty,
    output logic [NUM_LISTS*CNT_WD-1:0] ll_size,
    output logic [CNT_WD-1:0]           free_cnt
);

    ll_state_e          state_q, state_d;
    ll_status_e         stat_q, chk_stat;
    logic [2:0]         op_q;
    logic [LID_WD-1:0]  list_q;
    logic [CNT_WD-1:0]  pos_q, walk_q, chk_walk, in_size;
    logic [DATA_WD-1:0] data_q;
    logic [PTR_WD-1:0]  cur_q, del_node, fl_head, fl_tail;

    logic [DATA_WD-1:0] data_mem [DATA_DEPTH];
    logic [PTR_WD-1:0]  nxt_mem  [DATA_DEPTH];
    logic [PTR_WD-1:0]  head_q   [NUM_LISTS];
    logic [PTR_WD-1:0]  tail_q   [NUM_LISTS];
    logic [CNT_WD-1:0]  size_q   [NUM_LISTS];

    logic exec_ok, fl_pop, fl_push, fl_splice;

    assign req_rdy  = (state_q == S_IDLE);
    assign in_size  = size_q[req_list];
    assign exec_ok  = (state_q == S_EXEC) && (stat_q == ST_OK);
    assign del_node = (pos_q == '0) ? head_q[list_q] : nxt_mem[cur_q];
    assign fl_pop    = exec_ok && (op_q == OP_PUSH_TAIL || op_q == OP_INSERT_AT);
    assign fl_push   = exec_ok && (op_q == OP_DELETE_AT);
    assign fl_splice = exec_ok && (op_q == OP_CLEAR) && (size_q[list_q] != '0);

    // Validate the incoming request and size its walk; errors never walk
    always_comb begin
        chk_stat = ST_OK;
        chk_walk = '0;
        case (req_op)
            OP_PUSH_TAIL: if (free_cnt == '0) chk_stat = ST_FULL;
            OP_INSERT_AT: begin
                if (free_cnt == '0)        chk_stat = ST_FULL;
                else if (req_pos > in_size) chk_stat = ST_BAD;
                else if (req_pos != '0)     chk_walk = req_pos - CNT_WD'(1);
            end
            OP_DELETE_AT: begin
                if (in_size == '0)           chk_stat = ST_EMPTY;
                else if (req_pos >= in_size) chk_stat = ST_BAD;
                else if (req_pos != '0)      chk_walk = req_pos - CNT_WD'(1);
            end
            OP_READ_AT: begin
                if (in_size == '0)           chk_stat = ST_EMPTY;
                else if (req_pos >= in_size) chk_stat = ST_BAD;
                else                         chk_walk = req_pos;
            end
            OP_CLEAR: ;
            default: chk_stat = ST_BAD;
        endcase
    end

    // Per-list size and empty flags, list 0 in the low bits
    always_comb begin
        ll_size  = '0;
        ll_empty = '0;
        for (int l = 0; l < NUM_LISTS; l++) begin
            ll_size[l*CNT_WD +: CNT_WD] = size_q[l];
            ll_empty[l]                 = (size_q[l] == '0);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: walk only when there are hops to take
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_vld) state_d = (chk_walk == '0) ? S_EXEC : S_WALK;
            S_WALK: if (walk_q == CNT_WD'(1)) state_d = S_EXEC;
            S_EXEC: state_d = S_RESP;
            S_RESP: if (resp_rdy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Payload storage is written only for allocating ops and needs no reset
    always_ff @(posedge clk) begin
        if (fl_pop) data_mem[fl_head] <= data_q;
    end

    // Request capture, pointer walk, list-table updates and the response register
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            op_q        <= '0;
            list_q      <= '0;
            pos_q       <= '0;
            data_q      <= '0;
            stat_q      <= ST_OK;
            walk_q      <= '0;
            cur_q       <= '0;
            resp_vld    <= 1'b0;
            resp_data   <= '0;
            resp_status <= '0;
            for (int i = 0; i < DATA_DEPTH; i++) nxt_mem[i] <= PTR_WD'(i + 1);
            for (int l = 0; l < NUM_LISTS; l++) begin
                head_q[l] <= '0;
                tail_q[l] <= '0;
                size_q[l] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: if (req_vld) begin
                    op_q   <= req_op;
                    list_q <= req_list;
                    pos_q  <= req_pos;
                    data_q <= req_data;
                    stat_q <= chk_stat;
                    walk_q <= chk_walk;
                    cur_q  <= head_q[req_list];
                end
                S_WALK: begin
                    cur_q  <= nxt_mem[cur_q];
                    walk_q <= walk_q - CNT_WD'(1);
                end
                S_EXEC: begin
                    resp_vld    <= 1'b1;
                    resp_status <= stat_q;
                    resp_data   <= '0;
                    if (stat_q == ST_OK) begin
                        case (op_q)
                            OP_PUSH_TAIL: begin
                                if (size_q[list_q] != '0) nxt_mem[tail_q[list_q]] <= fl_head;
                                else                      head_q[list_q] <= fl_head;
                                tail_q[list_q] <= fl_head;
                                size_q[list_q] <= size_q[list_q] + CNT_WD'(1);
                            end
                            OP_INSERT_AT: begin
                                if (pos_q == '0) begin
                                    nxt_mem[fl_head] <= head_q[list_q];
                                    head_q[list_q]   <= fl_head;
                                    if (size_q[list_q] == '0) tail_q[list_q] <= fl_head;
                                end else begin
                                    nxt_mem[fl_head] <= nxt_mem[cur_q];
                                    nxt_mem[cur_q]   <= fl_head;
                                    if (cur_q == tail_q[list_q]) tail_q[list_q] <= fl_head;
                                end
                                size_q[list_q] <= size_q[list_q] + CNT_WD'(1);
                            end
                            OP_DELETE_AT: begin
                                resp_data <= data_mem[del_node];
                                if (pos_q == '0) begin
                                    head_q[list_q] <= nxt_mem[del_node];
                                end else begin
                                    nxt_mem[cur_q] <= nxt_mem[del_node];
                                    if (del_node == tail_q[list_q]) tail_q[list_q] <= cur_q;
                                end
                                if (free_cnt != '0) nxt_mem[fl_tail] <= del_node;
                                size_q[list_q] <= size_q[list_q] - CNT_WD'(1);
                            end
                            OP_READ_AT: resp_data <= data_mem[cur_q];
                            OP_CLEAR: begin
                                if (size_q[list_q] != '0 && free_cnt != '0)
                                    nxt_mem[fl_tail] <= head_q[list_q];
                                head_q[list_q] <= '0;
                                tail_q[list_q] <= '0;
                                size_q[list_q] <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RESP: if (resp_rdy) begin
                    resp_vld    <= 1'b0;
                    resp_data   <= '0;
                    resp_status <= '0;
                end
                default: ;
            endcase
        end
    end

    ll_free_list #(
        .DATA_DEPTH (DATA_DEPTH),
        .PTR_WD     (PTR_WD),
        .CNT_WD     (CNT_WD)
    ) u_free_list (
        .clk         (clk),
        .reset_n     (reset_n),
        .pop         (fl_pop),
        .head_nxt    (nxt_mem[fl_head]),
        .push        (fl_push),
        .push_node   (del_node),
        .splice      (fl_splice),
        .splice_head (head_q[list_q]),
        .splice_tail (tail_q[list_q]),
        .splice_cnt  (size_q[list_q]),
        .free_head   (fl_head),
        .free_tail   (fl_tail),
        .free_cnt    (free_cnt)
    );

endmodule

// File: tb/tb_ll_ptr_mgr.sv
// tb/tb_ll_ptr_mgr.sv - directed self-checking bench for ll_ptr_mgr
module tb_ll_ptr_mgr;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [2:0]  req_op = '0;
    logic [1:0]  req_list = '0;
    logic [4:0]  req_pos = '0;
    logic [31:0] req_data = '0;
    logic        resp_vld;
    logic        resp_rdy = 1'b1;
    logic [31:0] resp_data;
    logic [1:0]  resp_status;
    logic [3:0]  ll_empty;
    logic [19:0] ll_size;
    logic [4:0]  free_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic [1:0]  rs;
    int          lat;
    logic [31:0] held_data;

    ll_ptr_mgr dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_op      (req_op),
        .req_list    (req_list),
        .req_pos     (req_pos),
        .req_data    (req_data),
        .resp_vld    (resp_vld),
        .resp_rdy    (resp_rdy),
        .resp_data   (resp_data),
        .resp_status (resp_status),
        .ll_empty    (ll_empty),
        .ll_size     (ll_size),
        .free_cnt    (free_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    // Issue one request, return payload/status and acceptance-to-resp_vld latency (acceptance cycle = 1)
    task automatic do_req(input logic [2:0] op, input logic [1:0] lst, input logic [4:0] pos,
                          input logic [31:0] d, output logic [31:0] o_data,
                          output logic [1:0] o_stat, output int o_lat);
        @(negedge clk);
        req_op = op; req_list = lst; req_pos = pos; req_data = d; req_vld = 1'b1;
        @(posedge clk);
        #1 req_vld = 1'b0;
        o_lat = 1;
        forever begin
            @(negedge clk);
            o_lat++;
            if (resp_vld) break;
            if (o_lat > 100) begin
                chk("resp_timeout", 64'(o_lat), 64'd0);
                break;
            end
        end
        o_data = resp_data;
        o_stat = resp_status;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_rdy", 64'(req_rdy), 64'd1);
        chk("rst_resp_vld", 64'(resp_vld), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_status", 64'(resp_status), 64'd0);
        chk("rst_ll_size", 64'(ll_size), 64'd0);
        chk("rst_ll_empty", 64'(ll_empty), 64'hF);
        chk("rst_free_cnt", 64'(free_cnt), 64'd16);
        reset_n = 1'b0;

        // Fill the pool through list 0, then overflow
        for (int i = 0; i < 16; i++) begin
            do_req(3'd0, 2'd0, 5'd0, 32'h100 + i, rd, rs, lat);
            chk($sformatf("push%0d_status", i), 64'(rs), 64'd0);
        end
        chk("full_free_cnt", 64'(free_cnt), 64'd0);
        do_req(3'd0, 2'd0, 5'd0, 32'hDEAD, rd, rs, lat);
        chk("push17_status", 64'(rs), 64'd1);
        chk("push17_size0", 64'(ll_size[4:0]), 64'd16);
        do_req(3'd3, 2'd0, 5'd15, 32'd0, rd, rs, lat);
        chk("read15_data", 64'(rd), 64'h10F);
        chk("read15_lat", 64'(lat), 64'd18);
        do_req(3'd4, 2'd0, 5'd0, 32'd0, rd, rs, lat);
        chk("clear_full_status", 64'(rs), 64'd0);
        chk("clear_full_free", 64'(free_cnt), 64'd16);
        chk("clear_full_empty", 64'(ll_empty), 64'hF);

        // Insert in the middle of list 1
        do_reset();
        do_req(3'd0, 2'd1, 5'd0, 32'hA, rd, rs, lat);
        do_req(3'd0, 2'd1, 5'd0, 32'hB, rd, rs, lat);
        do_req(3'd0, 2'd1, 5'd0, 32'hC, rd, rs, lat);
        do_req(3'd1, 2'd1, 5'd1, 32'hD, rd, rs, lat);
        chk("ins1_status", 64'(rs), 64'd0);
        chk("ins1_lat", 64'(lat), 64'd3);
        chk("ins1_size1", 64'(ll_size[9:5]), 64'd4);
        do_req(3'd3, 2'd1, 5'd0, 32'd0, rd, rs, lat);
        chk("l1_read0", 64'(rd), 64'hA);
        do_req(3'd3, 2'd1, 5'd1, 32'd0, rd, rs, lat);
        chk("l1_read1", 64'(rd), 64'hD);
        do_req(3'd3, 2'd1, 5'd2, 32'd0, rd, rs, lat);
        chk("l1_read2", 64'(rd), 64'hB);
        do_req(3'd3, 2'd1, 5'd3, 32'd0, rd, rs, lat);
        chk("l1_read3", 64'(rd), 64'hC);
        chk("l1_read3_lat", 64'(lat), 64'd6);

        // Delete the tail of list 2 and reuse the pool
        do_reset();
        do_req(3'd0, 2'd2, 5'd0, 32'hA, rd, rs, lat);
        do_req(3'd0, 2'd2, 5'd0, 32'hB, rd, rs, lat);
        do_req(3'd0, 2'd2, 5'd0, 32'hC, rd, rs, lat);
        do_req(3'd2, 2'd2, 5'd2, 32'd0, rd, rs, lat);
        chk("del2_data", 64'(rd), 64'hC);
        chk("del2_status", 64'(rs), 64'd0);
        chk("del2_lat", 64'(lat), 64'd4);
        chk("del2_free", 64'(free_cnt), 64'd14);
        do_req(3'd0, 2'd2, 5'd0, 32'hE, rd, rs, lat);
        do_req(3'd3, 2'd2, 5'd2, 32'd0, rd, rs, lat);
        chk("l2_read2", 64'(rd), 64'hE);
        chk("l2_free", 64'(free_cnt), 64'd13);

        // Error responses leave every table alone
        do_req(3'd2, 2'd3, 5'd0, 32'd0, rd, rs, lat);
        chk("del_empty_status", 64'(rs), 64'd2);
        chk("del_empty_lat", 64'(lat), 64'd3);
        do_req(3'd0, 2'd1, 5'd0, 32'h11, rd, rs, lat);
        do_req(3'd0, 2'd1, 5'd0, 32'h22, rd, rs, lat);
        do_req(3'd3, 2'd1, 5'd5, 32'd0, rd, rs, lat);
        chk("badpos_status", 64'(rs), 64'd3);
        chk("badpos_data", 64'(rd), 64'd0);
        do_req(3'd6, 2'd1, 5'd0, 32'd0, rd, rs, lat);
        chk("badop_status", 64'(rs), 64'd3);
        chk("err_ll_size", 64'(ll_size), 64'h00C40);
        chk("err_free", 64'(free_cnt), 64'd11);

        // CLEAR a 5-node list with back-pressure on the response
        for (int i = 0; i < 5; i++) do_req(3'd0, 2'd3, 5'd0, 32'h30 + i, rd, rs, lat);
        chk("l3_size", 64'(ll_size[19:15]), 64'd5);
        chk("l3_free", 64'(free_cnt), 64'd6);
        resp_rdy = 1'b0;
        do_req(3'd4, 2'd3, 5'd0, 32'd0, rd, rs, lat);
        held_data = rd;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_resp_vld", i), 64'(resp_vld), 64'd1);
            chk($sformatf("hold%0d_req_rdy", i), 64'(req_rdy), 64'd0);
            chk($sformatf("hold%0d_data", i), 64'(resp_data), 64'(held_data));
            chk($sformatf("hold%0d_status", i), 64'(resp_status), 64'd0);
        end
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("clear_resp_vld_dropped", 64'(resp_vld), 64'd0);
        chk("clear_req_rdy", 64'(req_rdy), 64'd1);
        chk("clear_free", 64'(free_cnt), 64'd11);
        chk("clear_empty3", 64'(ll_empty[3]), 64'd1);
        chk("clear_invariant", 64'(ll_size[4:0] + ll_size[9:5] + ll_size[14:10] + ll_size[19:15] + free_cnt), 64'd16);

        // Reset in the middle of a long walk
        for (int i = 0; i < 11; i++) do_req(3'd0, 2'd0, 5'd0, 32'h50 + i, rd, rs, lat);
        chk("l0_size11", 64'(ll_size[4:0]), 64'd11);
        chk("l0_free0", 64'(free_cnt), 64'd0);
        @(negedge clk);
        req_op = 3'd3; req_list = 2'd0; req_pos = 5'd10; req_vld = 1'b1;
        @(posedge clk);
        #1 req_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("walk_req_rdy_low", 64'(req_rdy), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("mid_rst_req_rdy", 64'(req_rdy), 64'd1);
        chk("mid_rst_resp_vld", 64'(resp_vld), 64'd0);
        chk("mid_rst_resp_data", 64'(resp_data), 64'd0);
        chk("mid_rst_resp_status", 64'(resp_status), 64'd0);
        chk("mid_rst_ll_size", 64'(ll_size), 64'd0);
        chk("mid_rst_ll_empty", 64'(ll_empty), 64'hF);
        chk("mid_rst_free", 64'(free_cnt), 64'd16);
        @(negedge clk);
        reset_n = 1'b0;
        do_req(3'd0, 2'd0, 5'd0, 32'h77, rd, rs, lat);
        chk("post_rst_push_status", 64'(rs), 64'd0);
        chk("post_rst_free", 64'(free_cnt), 64'd15);
        do_req(3'd3, 2'd0, 5'd0, 32'd0, rd, rs, lat);
        chk("post_rst_read0", 64'(rd), 64'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ll_ptr_mgr.md
LL_PTR_MGR -- requirements
Module: ll_ptr_mgr

Interface
REQ-001 SHALL have parameter DATA_DEPTH, default 16: total node pool shared by all lists (power of two).
REQ-002 SHALL have parameter DATA_WD, default 32: payload width per node.
REQ-003 SHALL have parameter NUM_LISTS, default 4: independent lists sharing the pool.
REQ-004 SHALL derive PTR_WD=$clog2(DATA_DEPTH), CNT_WD=PTR_WD+1, LID_WD=max(1,$clog2(NUM_LISTS)).
REQ-005 SHALL have ports, with clock and reset first:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-high reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  block can accept a request.
- req_op  in  3  0 PUSH_TAIL, 1 INSERT_AT, 2 DELETE_AT, 3 READ_AT, 4 CLEAR; 5-7 reserved.
- req_list  in  LID_WD  target list.
- req_pos  in  CNT_WD  0-based position.
- req_data  in  DATA_WD  write payload.
- resp_vld  out  1  response valid.
- resp_rdy  in  1  response accepted.
- resp_data  out  DATA_WD  read or deleted payload, otherwise 0.
- resp_status  out  2  0 OK, 1 FULL, 2 EMPTY, 3 BADPOS/BADOP.
- ll_empty  out  NUM_LISTS  per-list empty flag.
- ll_size  out  NUM_LISTS*CNT_WD  per-list node count, list 0 in the LSBs.
- free_cnt  out  CNT_WD  free nodes remaining.

Function
REQ-006 SHALL store nodes as true linked lists: data_mem and nxt_mem indexed by node pointer, plus per-list head, tail and size, and a free list with free_head, free_tail and free_cnt.
REQ-007 SHALL implement the FSM IDLE -> (WALK) -> EXEC -> RESP -> IDLE; req_rdy=1 only in IDLE; a request is accepted on req_vld&req_rdy, and its fields are registered on acceptance.
REQ-008 SHALL go from IDLE to EXEC when the op is PUSH_TAIL or CLEAR, or when the effective walk count is 0; otherwise it goes to WALK.
REQ-009 WALK SHALL follow nxt_mem one hop per cycle from head until it reaches node pos-1 (INSERT_AT, DELETE_AT) or node pos (READ_AT). A position-p op therefore completes in 3+max(0,p-1) or 3+p cycles from acceptance to resp_vld.
REQ-010 PUSH_TAIL SHALL pop free_head, write req_data, link the old tail to it, update tail/head, and increment size.
REQ-011 INSERT_AT pos SHALL be legal for 0<=pos<=size; pos=0 updates head, and pos=size behaves as PUSH_TAIL.
REQ-012 DELETE_AT pos SHALL be legal for pos<size. It unlinks the node, returns its payload on resp_data, appends the node to the free tail, and fixes head/tail.
REQ-013 READ_AT SHALL return data_mem of node pos with no state change.
REQ-014 CLEAR SHALL splice the whole list onto the free tail in one EXEC cycle (O(1)) and zero size/head/tail; CLEAR of an empty list returns OK.
REQ-015 Errors SHALL change no state and skip WALK:
- insert/push with free_cnt==0 returns FULL.
- delete/read on an empty list returns EMPTY.
- an out-of-range pos returns BADPOS.
- a reserved op returns BADOP (code 3).
REQ-016 resp_vld SHALL hold with stable resp_data/resp_status until resp_rdy; the FSM returns to IDLE on the cycle after the handshake.
REQ-017 State updates SHALL occur only in EXEC. ll_size, ll_empty and free_cnt SHALL update in the cycle after EXEC. Invariant: sum(ll_size)+free_cnt==DATA_DEPTH at all times.
REQ-018 Reads from data_mem/nxt_mem SHALL be combinational at the current pointer (flop arrays), so there is no read latency beyond the FSM.

Reset
REQ-019 When reset_n=1, asynchronously:
- the FSM goes to IDLE; req_rdy=1 once released.
- resp_vld=0, resp_data=0, resp_status=0.
- all lists are empty: ll_size=0, ll_empty all 1.
- free list is nodes 0..DATA_DEPTH-1 chained in order: free_head=0, free_tail=DATA_DEPTH-1, free_cnt=DATA_DEPTH.
REQ-020 A reset asserted mid-WALK or mid-RESP SHALL abandon the operation with no partial update surviving; data_mem contents need no reset.

Structure
REQ-021 Package ll_pkg SHALL hold: the op enum, the status enum, the FSM state enum, and default DATA_DEPTH/DATA_WD/NUM_LISTS constants.
REQ-022 The free-list manager (pop/append/splice, free_cnt) SHALL be the sub-module ll_free_list; the list tables and FSM stay in ll_ptr_mgr.

Verification
REQ-023 Reset, then 16 PUSH_TAIL to list 0 -> each OK, free_cnt=0; a 17th push -> FULL, ll_size[0]=16 unchanged.
REQ-024 List 1 = {A,B,C}; INSERT_AT pos 1 data D -> READ_AT 0..3 returns A,D,B,C; READ_AT 3 resp_vld arrives 6 cycles after acceptance.
REQ-025 List 2 = {A,B,C}; DELETE_AT 2 -> resp_data=C, OK; PUSH_TAIL E -> READ_AT 2 returns E (reuses freed node); free_cnt is back to DATA_DEPTH-3.
REQ-026 DELETE_AT on empty list 3 -> EMPTY; READ_AT pos 5 on a 2-node list -> BADPOS; op 6 -> BADOP; no state change after any of these.
REQ-027 CLEAR a 5-node list while resp_rdy is held 0 for 4 cycles -> resp_vld is held and req_rdy stays 0; after the handshake, free_cnt rises by 5 and ll_empty for that list is 1.
REQ-028 Assert reset mid-WALK of READ_AT 10 -> all outputs take their reset values; the next PUSH_TAIL returns OK using node 0.
